// File: rtl/dec_pkg.sv
// Shared mode encodings and the one-hot helper for the sequenced N-to-2^N decoder.
package dec_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_DIRECT = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_AUTO   = 2'b11;

  // Bits at or above width stay clear so narrow builds never see stray ones.
  function automatic logic [63:0] onehot(input logic [5:0] idx, input int unsigned width);
    logic [63:0] result;
    result = '0;
    if (32'(idx) < width) result[idx] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Auto-scan prescaler: counts enabled cycles and flags the terminal count.
module scan_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign tick = !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (clear || tick) count <= '0;
      else               count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/dec_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder whose index comes from a direct select,
// a rising-edge step input, or a prescaled auto-scan.
module dec_nto2n_seq
  import dec_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int PRESCALE   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  step,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic INACT = (ACTIVE_LOW != 0);
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  logic [1:0]       mode_q;
  logic             step_q;
  logic             mode_change;
  logic             auto_run;
  logic             tick;
  logic             inc;
  logic [SEL_W-1:0] idx_next;
  logic [OUT_W-1:0] dec_val;
  logic [OUT_W-1:0] out_next;

  assign mode_change = (mode != mode_q);
  assign auto_run    = (mode == MODE_AUTO) && !mode_change;

  scan_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clear (!auto_run),
    .tick  (tick)
  );

  // Out is decoded from the next index so idx and out land on the same edge.
  always_comb begin
    inc      = 1'b0;
    idx_next = idx;
    case (mode)
      MODE_DIRECT: idx_next = sel;
      MODE_STEP:   inc = !mode_change && step && !step_q;
      MODE_AUTO:   inc = tick;
      default:     inc = 1'b0;
    endcase
    if (inc) idx_next = idx + SEL_W'(1);
    dec_val  = OUT_W'(onehot(6'(idx_next), OUT_W));
    out_next = (mode == MODE_OFF) ? {OUT_W{INACT}} : (dec_val ^ {OUT_W{INACT}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      mode_q <= MODE_OFF;
      step_q <= 1'b0;
      out    <= {OUT_W{INACT}};
      valid  <= 1'b0;
      wrap   <= 1'b0;
    end else if (en) begin
      idx    <= idx_next;
      mode_q <= mode;
      step_q <= step;
      out    <= out_next;
      valid  <= (mode != MODE_OFF);
      wrap   <= inc && (idx == IDX_MAX);
    end else begin
      wrap   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_nto2n_seq.sv
// Directed bench for dec_nto2n_seq: one active-high and one active-low build share stimulus.
module tb_dec_nto2n_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] sel = 3'd0;
  logic       step = 1'b0;

  logic [7:0] out;
  logic [2:0] idx;
  logic       valid;
  logic       wrap;
  logic [7:0] al_out;
  logic [2:0] al_idx;
  logic       al_valid;
  logic       al_wrap;

  int vectors = 0;
  int miscompares = 0;

  dec_nto2n_seq #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .step(step),
    .out(out), .idx(idx), .valid(valid), .wrap(wrap)
  );

  dec_nto2n_seq #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .step(step),
    .out(al_out), .idx(al_idx), .valid(al_valid), .wrap(al_wrap)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic e, input logic [1:0] m, input logic [2:0] s, input logic st);
    en   = e;
    mode = m;
    sel  = s;
    step = st;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [2:0] exp_idx, input logic exp_valid, input logic exp_wrap);
    logic [7:0] exp_out;
    exp_out = exp_valid ? (8'b1 << exp_idx) : 8'h00;
    vectors++;
    assert (idx === exp_idx) else begin
      miscompares++;
      $error("[TB] FAIL %s idx: got %0d expected %0d", tag, idx, exp_idx);
    end
    vectors++;
    assert (out === exp_out) else begin
      miscompares++;
      $error("[TB] FAIL %s out: got %b expected %b", tag, out, exp_out);
    end
    vectors++;
    assert (valid === exp_valid) else begin
      miscompares++;
      $error("[TB] FAIL %s valid: got %b expected %b", tag, valid, exp_valid);
    end
    vectors++;
    assert (wrap === exp_wrap) else begin
      miscompares++;
      $error("[TB] FAIL %s wrap: got %b expected %b", tag, wrap, exp_wrap);
    end
    vectors++;
    assert (al_out === ~exp_out) else begin
      miscompares++;
      $error("[TB] FAIL %s al_out: got %b expected %b", tag, al_out, ~exp_out);
    end
    vectors++;
    assert ((al_idx === exp_idx) && (al_valid === exp_valid) && (al_wrap === exp_wrap)) else begin
      miscompares++;
      $error("[TB] FAIL %s al_status: got %0d/%b/%b expected %0d/%b/%b",
             tag, al_idx, al_valid, al_wrap, exp_idx, exp_valid, exp_wrap);
    end
  endtask

  initial begin
    $display("[TB] start");
    #1 rst_n = 1'b0;
    #1;
    check_output("reset", 3'd0, 1'b0, 1'b0);
    vectors++;
    assert (al_out === 8'hFF) else begin
      miscompares++;
      $error("[TB] FAIL reset_al_literal: got %h expected ff", al_out);
    end
    #10 rst_n = 1'b1;

    // DIRECT load and full sweep
    apply_stimulus(1'b1, 2'b01, 3'd5, 1'b0);
    cycle();
    check_output("direct5", 3'd5, 1'b1, 1'b0);
    vectors++;
    assert (out === 8'b0010_0000) else begin
      miscompares++;
      $error("[TB] FAIL direct5_literal: got %b expected 00100000", out);
    end
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 2'b01, 3'(i), 1'b0);
      cycle();
      check_output($sformatf("sweep%0d", i), 3'(i), 1'b1, 1'b0);
    end
    apply_stimulus(1'b1, 2'b01, 3'd2, 1'b0);
    cycle();
    check_output("direct2", 3'd2, 1'b1, 1'b0);
    vectors++;
    assert (al_out === 8'b1111_1011) else begin
      miscompares++;
      $error("[TB] FAIL al_direct2_literal: got %b expected 11111011", al_out);
    end

    // STEP pulses across the wrap, then a long held step
    apply_stimulus(1'b1, 2'b01, 3'd6, 1'b0);
    cycle();
    check_output("direct6", 3'd6, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b10, 3'd0, 1'b0);
    cycle();
    check_output("step_entry", 3'd6, 1'b1, 1'b0);
    step = 1'b1; cycle(); check_output("step_a_hi", 3'd7, 1'b1, 1'b0);
    step = 1'b0; cycle(); check_output("step_a_lo", 3'd7, 1'b1, 1'b0);
    step = 1'b1; cycle(); check_output("step_b_hi", 3'd0, 1'b1, 1'b1);
    step = 1'b0; cycle(); check_output("step_b_lo", 3'd0, 1'b1, 1'b0);
    step = 1'b1; cycle(); check_output("step_c_hi", 3'd1, 1'b1, 1'b0);
    step = 1'b0; cycle(); check_output("step_c_lo", 3'd1, 1'b1, 1'b0);
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_output($sformatf("step_hold%0d", i), 3'd2, 1'b1, 1'b0);
    end
    step = 1'b0;

    // AUTO full scan with wrap on the eighth step
    apply_stimulus(1'b1, 2'b01, 3'd0, 1'b0);
    cycle();
    check_output("direct0", 3'd0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b11, 3'd0, 1'b0);
    cycle();
    check_output("auto_entry", 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      cycle();
      check_output($sformatf("auto_k%0d", k), 3'((k / 4) % 8), 1'b1, k == 32);
    end

    // en low right after the wrap: wrap drops, everything else freezes
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_output($sformatf("en_off%0d", i), 3'd0, 1'b1, 1'b0);
    end
    en = 1'b1;
    for (int k = 33; k <= 35; k++) begin
      cycle();
      check_output($sformatf("auto_k%0d", k), 3'd0, 1'b1, 1'b0);
    end
    cycle(); check_output("auto_k36", 3'd1, 1'b1, 1'b0);
    cycle(); check_output("auto_k37", 3'd1, 1'b1, 1'b0);
    cycle(); check_output("auto_k38", 3'd1, 1'b1, 1'b0);

    // AUTO -> STEP -> AUTO: switching edges never increment
    apply_stimulus(1'b1, 2'b10, 3'd0, 1'b0);
    cycle(); check_output("sw_step0", 3'd1, 1'b1, 1'b0);
    cycle(); check_output("sw_step1", 3'd1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b11, 3'd0, 1'b0);
    cycle(); check_output("sw_auto_entry", 3'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check_output($sformatf("sw_auto%0d", i), 3'd1, 1'b1, 1'b0);
    end
    cycle(); check_output("sw_auto4", 3'd2, 1'b1, 1'b0);

    // Entering STEP with step already high is not an edge
    step = 1'b1;
    cycle(); check_output("pre_step_hi", 3'd2, 1'b1, 1'b0);
    mode = 2'b10;
    cycle(); check_output("step_enter_hi", 3'd2, 1'b1, 1'b0);
    cycle(); check_output("step_still_hi", 3'd2, 1'b1, 1'b0);
    step = 1'b0;
    cycle(); check_output("step_release", 3'd2, 1'b1, 1'b0);
    step = 1'b1;
    cycle(); check_output("step_fresh", 3'd3, 1'b1, 1'b0);
    step = 1'b0;

    // OFF keeps idx but blanks the outputs
    mode = 2'b00;
    cycle(); check_output("off0", 3'd3, 1'b0, 1'b0);
    cycle(); check_output("off1", 3'd3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an AUTO scan
    mode = 2'b11;
    cycle(); check_output("auto2_entry", 3'd3, 1'b1, 1'b0);
    cycle(); check_output("auto2_k1", 3'd3, 1'b1, 1'b0);
    cycle(); check_output("auto2_k2", 3'd3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset", 3'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    cycle(); check_output("post_reset_entry", 3'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check_output($sformatf("post_reset%0d", i), 3'd0, 1'b1, 1'b0);
    end
    cycle(); check_output("post_reset4", 3'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
